abs_delta_decoder: RTL and testbench
====================================

# abs_delta_decoder

- Receive-side counterpart of the absolute-difference encoder.
- Rebuilds an 8-bit sample stream from a keyframe followed by (sign, magnitude) deltas, where magnitude is the 9-bit |a−b| the encoder emits and sign records which operand was larger.
- Sits between the delta link and sample consumers, with valid/ready on both sides and a one-entry output register.

## Interface
Parameters:
- DW, 8, sample width
- MW, DW+1, delta magnitude width (matches encoder output width)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input token present
- in_ready  out  1  decoder accepts token this cycle
- in_key  in  1  1: in_mag[DW-1:0] is an absolute sample (keyframe); 0: delta
- in_sign  in  1  delta only: 0 = add (new ≥ prev), 1 = subtract
- in_mag  in  MW  delta magnitude, or keyframe value in low DW bits
- out_valid  out  1  reconstructed sample present
- out_ready  in  1  consumer accepts sample
- out_data  out  DW  reconstructed sample
- out_err  out  1  qualified by out_valid; sample was clamped, or the delta arrived before any keyframe
- locked  out  1  1 once a keyframe has been accepted

## Operation
- Transfer occurs when valid && ready on a port.
- in_ready = !out_valid || out_ready. The path is combinational from out_ready, and there is no other in_ready dependency.
- State machine with two states:
  - UNLOCKED (reset state):
    - Keyframe: prev ← in_mag[DW-1:0]; emit it with err=0; go to LOCKED.
    - Delta: consumed, then emit out_data=0, err=1. prev is unchanged and the state stays UNLOCKED.
  - LOCKED:
    - Keyframe: reloads prev and emits that value, err=0.
    - Delta: computes sum = {2'b0,prev} ± {1'b0,in_mag} in DW+2 bits, signed.
      - sum < 0 → result 0, err=1.
      - sum > 2^DW−1 → result 2^DW−1, err=1.
      - Otherwise result = sum[DW-1:0], err=0.
    - prev ← result on every delta, including clamped ones.
- in_key=1 ignores in_sign and in_mag[MW-1].
- A subtract delta with magnitude 0 is legal and gives result = prev, err=0.
- locked mirrors state == LOCKED.

## Timing
- Reset values: out_valid=0, out_data=0, out_err=0, locked=0, prev=0, state UNLOCKED. in_ready=1 in reset since out_valid=0.
- Latency: input accepted in cycle N → out_valid=1 with its data in cycle N+1.
- Full throughput of 1 token/cycle when out_ready is held high.
- Output holds stable (out_data, out_err) while out_valid && !out_ready.
- Simultaneous output drain and new input acceptance in the same cycle is required; the register reloads with no bubble.
- out_valid falls only after an output transfer with no new input accepted.
- Reset mid-stream: all state is cleared immediately. The next delta is treated as pre-keyframe (error).
- prev updates in the same cycle the input is accepted. Back-to-back deltas chain correctly.

## Structure
- Shared package abs_delta_pkg holds:
  - DW/MW defaults
  - state enum {UNLOCKED, LOCKED}
  - token field constants (KEY, SIGN_SUB)
- The encoder side uses the same package.
- One natural sub-module: abs_delta_sat_add, a combinational prev ± mag with clamp and err. It is reusable by a future encoder-side self-check.
- The rest of the block is the FSM plus the output register in the top.

## Test plan
- Reset, then delta (sign=0, mag=5) before any key → one output 0, err=1, locked=0. Then key 100 → output 100, err=0, locked=1.
- Key 100, +20, −50, −0, +135 → outputs 100, 120, 70, 70, 205, all err=0, one per cycle with out_ready=1.
- Clamping: key 250, +10 → 255 err=1. Then −255 → 0 err=0. Then −1 → 0 err=1. Then +511 → 255 err=1.
- Backpressure: stream of 6 tokens with out_ready low on cycles 2–4.
  - in_ready must be low while the output is full and stalled.
  - The output must hold its value.
  - There must be no loss or duplication.
  - The sequence must match an unstalled reference model.
- Mid-stream keyframe: key 10, +5, key 200, −1 → 10, 15, 200, 199.
- Async reset asserted while out_valid=1 and stalled:
  - out_valid must drop without waiting for a clock.
  - After release, delta +3 → 0 err=1.
- Random soak: encoder model |a−b| with sign feeding random a/b pairs, plus random out_ready. The decoded stream must equal the original a sequence with err never set.

Source files
------------

// File: rtl/abs_delta_pkg.sv
// Shared definitions for the absolute-difference delta link (encoder and decoder).
// Contents:
//   DW_DEF / MW_DEF : default sample width and delta magnitude width
//   state_e         : decoder lock state
//   KEY, SIGN_SUB   : token field encodings for in_key / in_sign
package abs_delta_pkg;

  localparam int DW_DEF = 8;
  localparam int MW_DEF = DW_DEF + 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // in_key value that marks an absolute sample
  localparam logic KEY      = 1'b1;
  // in_sign value that means "new sample = prev - magnitude"
  localparam logic SIGN_SUB = 1'b1;

endpackage

// File: rtl/abs_delta_sat_add.sv
// Combinational prev +/- magnitude with clamping to the unsigned DW-bit range.
// Ports:
//   prev_i   : previous reconstructed sample (unsigned, DW bits)
//   mag_i    : delta magnitude (unsigned, MW bits, MW > DW)
//   sub_i    : 1 = subtract magnitude, 0 = add
//   result_o : clamped result
//   err_o    : 1 when the true result fell outside 0 .. 2^DW-1
module abs_delta_sat_add #(
  parameter int DW = 8,
  parameter int MW = DW + 1
) (
  input  logic [DW-1:0] prev_i,
  input  logic [MW-1:0] mag_i,
  input  logic          sub_i,
  output logic [DW-1:0] result_o,
  output logic          err_o
);

  // One extra bit over the magnitude keeps the sign of the true sum.
  localparam int SW = MW + 1;

  logic [SW-1:0] a_ext;
  logic [SW-1:0] b_ext;
  logic [SW-1:0] sum;
  logic          neg;
  logic          over;

  assign a_ext = {{(SW-DW){1'b0}}, prev_i};
  assign b_ext = {1'b0, mag_i};
  assign sum   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

  // Two's-complement: MSB set means the result went below zero.
  assign neg  = sum[SW-1];
  // Non-negative but with any bit above the sample width set means overflow.
  assign over = !neg && (|sum[SW-2:DW]);

  always_comb begin
    result_o = sum[DW-1:0];
    if (neg) begin
      result_o = '0;
    end else if (over) begin
      result_o = '1;
    end
  end

  assign err_o = neg | over;

endmodule

// File: rtl/abs_delta_decoder.sv
// Rebuilds a DW-bit sample stream from keyframes and (sign, magnitude) deltas.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input token handshake
//   in_key, in_sign       : token type and delta direction
//   in_mag                : delta magnitude, or keyframe value in low DW bits
//   out_valid / out_ready : output sample handshake (one-entry output register)
//   out_data, out_err     : reconstructed sample and clamp / pre-keyframe flag
//   locked                : a keyframe has been accepted since reset
module abs_delta_decoder
  import abs_delta_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int MW = DW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_key,
  input  logic          in_sign,
  input  logic [MW-1:0] in_mag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err,
  output logic          locked
);

  state_e        state_q, state_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_err_q, out_err_d;

  logic [DW-1:0] delta_res;
  logic          delta_err;
  logic          accept;

  abs_delta_sat_add #(
    .DW (DW),
    .MW (MW)
  ) u_sat_add (
    .prev_i   (prev_q),
    .mag_i    (in_mag),
    .sub_i    (in_sign == SIGN_SUB),
    .result_o (delta_res),
    .err_o    (delta_err)
  );

  // The output register can take a new sample when empty or being drained now.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      if (in_key == KEY) begin
        prev_d     = in_mag[DW-1:0];
        out_data_d = in_mag[DW-1:0];
        out_err_d  = 1'b0;
        state_d    = LOCKED;
      end else if (state_q == LOCKED) begin
        // Clamped results still become the new reference sample.
        prev_d     = delta_res;
        out_data_d = delta_res;
        out_err_d  = delta_err;
      end else begin
        // Delta with no reference yet: consume it and flag the output.
        out_data_d = '0;
        out_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_abs_delta_decoder.sv
// Scoreboard bench for abs_delta_decoder: expected samples are queued when a
// token is accepted and compared when the decoder hands a sample over.
module tb_abs_delta_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_key = 1'b0;
  logic       in_sign = 1'b0;
  logic [8:0] in_mag = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_err;
  logic       locked;

  abs_delta_decoder #(.DW(8), .MW(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int cyc      = 0;
  int last_wait;

  logic [8:0] sb_q[$];      // {err, data}
  bit  rand_rdy = 1'b0;
  bit  stall_en = 1'b0;
  int  s0, s1;

  // reference model state
  bit       m_locked = 1'b0;
  int       m_prev   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [8:0] model_step(input logic key, input logic sign, input logic [8:0] mag);
    int s;
    logic [8:0] r;
    if (key) begin
      m_prev   = int'(mag[7:0]);
      m_locked = 1'b1;
      r = {1'b0, mag[7:0]};
    end else if (!m_locked) begin
      r = {1'b1, 8'd0};
    end else begin
      s = sign ? (m_prev - int'(mag)) : (m_prev + int'(mag));
      if (s < 0) begin
        m_prev = 0;   r = {1'b1, 8'd0};
      end else if (s > 255) begin
        m_prev = 255; r = {1'b1, 8'd255};
      end else begin
        m_prev = s;   r = {1'b0, 8'(s)};
      end
    end
    return r;
  endfunction

  // Advance to just after the next rising edge and update out_ready policy.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else if (stall_en) out_ready = !(cyc >= s0 && cyc <= s1);
  endtask

  task automatic send(input logic key, input logic sign, input logic [8:0] mag,
                      input logic [7:0] ed, input logic ee, input bit use_model);
    int waits;
    logic [8:0] mr;
    in_valid = 1'b1;
    in_key   = key;
    in_sign  = sign;
    in_mag   = mag;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 100) begin
        chk("send_timeout", 1, 0);
        break;
      end
      tick();
    end
    mr = model_step(key, sign, mag);
    if (use_model) sb_q.push_back(mr);
    else sb_q.push_back({ee, ed});
    last_wait = waits;
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Output monitor: compares transfers and checks hold-while-stalled.
  bit         hold_pending = 1'b0;
  logic [8:0] hold_val;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else if (out_valid) begin
      if (hold_pending) chk("hold_stable", int'({out_err, out_data}), int'(hold_val));
      if (out_ready) begin
        hold_pending = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          n_out++;
          chk("out_data", int'(out_data), int'(e[7:0]));
          chk("out_err", int'(out_err), int'(e[8]));
          $display("out data=%0d err=%0d exp=%0d/%0d", out_data, out_err, e[7:0], e[8]);
        end
      end else begin
        chk("in_ready_stall", int'(in_ready), 0);
        hold_pending = 1'b1;
        hold_val = {out_err, out_data};
      end
    end
  end

  initial begin
    int a, a_prev, n0;
    logic [8:0] mag;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // delta before keyframe, then keyframe
    send(1'b0, 1'b0, 9'd5, 8'd0, 1'b1, 1'b0);
    drain();
    chk("prekey_locked", int'(locked), 0);
    send(1'b1, 1'b0, 9'd100, 8'd100, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_data", int'(out_data), 100);
    drain();
    chk("key_locked", int'(locked), 1);

    // basic chain, full throughput
    send(1'b1, 1'b0, 9'd100, 8'd100, 1'b0, 1'b0); chk("thru0", last_wait, 0);
    send(1'b0, 1'b0, 9'd20,  8'd120, 1'b0, 1'b0); chk("thru1", last_wait, 0);
    send(1'b0, 1'b1, 9'd50,  8'd70,  1'b0, 1'b0); chk("thru2", last_wait, 0);
    send(1'b0, 1'b1, 9'd0,   8'd70,  1'b0, 1'b0); chk("thru3", last_wait, 0);
    send(1'b0, 1'b0, 9'd135, 8'd205, 1'b0, 1'b0); chk("thru4", last_wait, 0);
    drain();

    // clamping; keyframe ignores sign and magnitude MSB
    send(1'b1, 1'b1, 9'h1FA, 8'd250, 1'b0, 1'b0);
    send(1'b0, 1'b0, 9'd10,  8'd255, 1'b1, 1'b0);
    send(1'b0, 1'b1, 9'd255, 8'd0,   1'b0, 1'b0);
    send(1'b0, 1'b1, 9'd1,   8'd0,   1'b1, 1'b0);
    send(1'b0, 1'b0, 9'd511, 8'd255, 1'b1, 1'b0);
    drain();

    // mid-stream keyframe
    send(1'b1, 1'b0, 9'd10,  8'd10,  1'b0, 1'b0);
    send(1'b0, 1'b0, 9'd5,   8'd15,  1'b0, 1'b0);
    send(1'b1, 1'b0, 9'd200, 8'd200, 1'b0, 1'b0);
    send(1'b0, 1'b1, 9'd1,   8'd199, 1'b0, 1'b0);
    drain();

    // backpressure: out_ready low on cycles 2..4 of a 6-token stream
    n0 = n_out;
    s0 = cyc + 2;
    s1 = cyc + 4;
    stall_en = 1'b1;
    send(1'b1, 1'b0, 9'd30,  8'd0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 9'd7,   8'd0, 1'b0, 1'b1);
    send(1'b0, 1'b1, 9'd3,   8'd0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 9'd100, 8'd0, 1'b0, 1'b1);
    send(1'b0, 1'b1, 9'd40,  8'd0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 9'd2,   8'd0, 1'b0, 1'b1);
    drain();
    stall_en = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", n_out - n0, 6);

    // asynchronous reset while stalled
    out_ready = 1'b0;
    send(1'b1, 1'b0, 9'd77, 8'd77, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    sb_q.delete();
    m_locked = 1'b0;
    m_prev   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b0, 1'b0, 9'd3, 8'd0, 1'b1, 1'b0);
    drain();

    // random soak through an encoder model
    rand_rdy = 1'b1;
    a_prev = int'($urandom_range(0, 255));
    send(1'b1, 1'b0, 9'(a_prev), 8'(a_prev), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 255));
      mag = (a >= a_prev) ? 9'(a - a_prev) : 9'(a_prev - a);
      send(1'b0, (a < a_prev), mag, 8'(a), 1'b0, 1'b0);
      a_prev = a;
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
